beam_profile_moments: RTL and testbench

Downstream neighbour of `bkg_subtraction` in the sensor-algorithm Qsys chain. It consumes one background-subtracted frame per Avalon-ST packet, with one signed 32-bit sample per channel in channel order. For each frame it accumulates the total intensity, the first moment and the peak channel. After end of packet it emits a fixed 5-word result packet that the readout / DMA stage turns into a beam position.

---
 rtl/sensor_algo_pkg.sv | 26 ++
 rtl/beam_profile_moments_sat_s32.sv | 25 ++
 rtl/beam_profile_moments.sv | 214 +++++++++++++++++++++
 tb/tb_beam_profile_moments.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_algo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sensor_algo_pkg
// Brief    : Shared types and constants for the sensor-algorithm result blocks.
// Revision : 1.0 - initial release
// ============================================================================
package sensor_algo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } state_e;

    localparam logic [7:0] RESULT_MAGIC = 8'hC5;
    localparam int         RESULT_WORDS = 5;
    localparam int         SUM_W        = 48;
    localparam int         MOM_W        = 64;

    // Flag positions inside result word 1
    localparam int FLAG_TRUNC_BIT   = 31;
    localparam int FLAG_SUM_SAT_BIT = 30;
    localparam int FLAG_MOM_SAT_BIT = 29;

endpackage
`default_nettype wire

// File: rtl/beam_profile_moments_sat_s32.sv
`default_nettype none
// ============================================================================
// Module   : sat_s32
// Brief    : Combinational signed saturation of a wide value to 32 bits.
// Revision : 1.0 - initial release
// ============================================================================
module sat_s32 #(
    parameter int IN_W = 48
) (
    input  logic [IN_W-1:0] val_i,
    output logic [31:0]     sat_o,
    output logic            clip_o
);

    // Value fits when every bit from 31 upward equals the sign bit
    always_comb begin
        clip_o = !((&val_i[IN_W-1:31]) || !(|val_i[IN_W-1:31]));
        sat_o  = val_i[31:0];
        if (clip_o) begin
            sat_o = val_i[IN_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

endmodule
`default_nettype wire

// File: rtl/beam_profile_moments.sv
`default_nettype none
// ============================================================================
// Module   : beam_profile_moments
// Brief    : Per-frame intensity sum, first moment and peak; emits 5-word result.
// Revision : 1.0 - initial release
// ============================================================================
module beam_profile_moments
    import sensor_algo_pkg::*;
#(
    parameter int MAX_CHANNELS = 163,
    parameter bit CLAMP_NEG    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in_data,
    input  logic        data_in_valid,
    output logic        data_in_ready,
    input  logic        data_in_startofpacket,
    input  logic        data_in_endofpacket,
    input  logic [1:0]  data_in_empty,
    output logic [31:0] data_out_data,
    output logic        data_out_valid,
    input  logic        data_out_ready,
    output logic        data_out_startofpacket,
    output logic        data_out_endofpacket,
    output logic [1:0]  data_out_empty
);

    localparam logic [31:0] c_peak_init = CLAMP_NEG ? 32'h0000_0000 : 32'h8000_0000;
    localparam logic [16:0] c_max_chan  = 17'(MAX_CHANNELS);
    localparam logic [2:0]  c_last_word = 3'(RESULT_WORDS - 1);

    state_e             state_q, state_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [MOM_W-1:0]   mom_q, mom_d;
    logic [31:0]        peak_q, peak_d;
    logic [15:0]        peak_idx_q, peak_idx_d;
    logic [15:0]        chan_q, chan_d;
    logic               trunc_q, trunc_d;
    logic [7:0]         abort_q, abort_d;
    logic [2:0]         word_q, word_d;
    logic [31:0]        out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_sop_q, out_sop_d;
    logic               out_eop_q, out_eop_d;

    logic               w_accept;
    logic               w_start;
    logic               w_in_range;
    logic [15:0]        w_idx;
    logic [31:0]        w_x;
    logic [SUM_W-1:0]   w_sum_base;
    logic [MOM_W-1:0]   w_mom_base;
    logic [31:0]        w_peak_base;
    logic [15:0]        w_peak_idx_base;
    logic               w_trunc_base;
    logic [MOM_W-1:0]   w_prod;
    logic [31:0]        w_sum_sat, w_mom_sat;
    logic               w_sum_clip, w_mom_clip;
    logic [31:0]        w_flags;
    logic [2:0]         w_sel;
    logic [31:0]        w_word;
    logic               w_unused;

    assign data_in_ready  = (state_q != ST_EMIT);
    assign w_accept       = data_in_valid && data_in_ready;
    assign w_start        = data_in_startofpacket;
    assign w_unused       = ^data_in_empty;

    // A sop beat restarts the frame, so it sees freshly cleared accumulators
    assign w_idx           = w_start ? 16'd0 : chan_q;
    assign w_sum_base      = w_start ? '0 : sum_q;
    assign w_mom_base      = w_start ? '0 : mom_q;
    assign w_peak_base     = w_start ? c_peak_init : peak_q;
    assign w_peak_idx_base = w_start ? 16'd0 : peak_idx_q;
    assign w_trunc_base    = w_start ? 1'b0 : trunc_q;

    assign w_x        = (CLAMP_NEG && data_in_data[31]) ? 32'd0 : data_in_data;
    assign w_in_range = ({1'b0, w_idx} < c_max_chan);
    assign w_prod     = $signed({48'd0, w_idx}) * $signed({{32{w_x[31]}}, w_x});

    sat_s32 #(.IN_W(SUM_W)) u_sat_sum (
        .val_i  (sum_q),
        .sat_o  (w_sum_sat),
        .clip_o (w_sum_clip)
    );

    sat_s32 #(.IN_W(MOM_W)) u_sat_mom (
        .val_i  (mom_q),
        .sat_o  (w_mom_sat),
        .clip_o (w_mom_clip)
    );

    // While a word is on the bus the mux already looks at the next one
    assign w_sel = out_valid_q ? (word_q + 3'd1) : word_q;

    always_comb begin
        w_flags                   = {16'd0, peak_idx_q};
        w_flags[FLAG_TRUNC_BIT]   = trunc_q;
        w_flags[FLAG_SUM_SAT_BIT] = w_sum_clip;
        w_flags[FLAG_MOM_SAT_BIT] = w_mom_clip;
        case (w_sel)
            3'd0:    w_word = {RESULT_MAGIC, abort_q, chan_q};
            3'd1:    w_word = w_flags;
            3'd2:    w_word = peak_q;
            3'd3:    w_word = w_sum_sat;
            default: w_word = w_mom_sat;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        mom_d       = mom_q;
        peak_d      = peak_q;
        peak_idx_d  = peak_idx_q;
        chan_d      = chan_q;
        trunc_d     = trunc_q;
        abort_d     = abort_q;
        word_d      = word_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;

        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (w_accept && (w_start || state_q == ST_ACCUM)) begin
                    if (w_start && state_q == ST_ACCUM && abort_q != 8'hFF) begin
                        abort_d = abort_q + 8'd1;
                    end
                    chan_d     = (w_idx == 16'hFFFF) ? 16'hFFFF : w_idx + 16'd1;
                    sum_d      = w_sum_base;
                    mom_d      = w_mom_base;
                    peak_d     = w_peak_base;
                    peak_idx_d = w_peak_idx_base;
                    trunc_d    = w_trunc_base || !w_in_range;
                    if (w_in_range) begin
                        sum_d = w_sum_base + {{(SUM_W-32){w_x[31]}}, w_x};
                        mom_d = w_mom_base + w_prod;
                        if ($signed(w_x) > $signed(w_peak_base)) begin
                            peak_d     = w_x;
                            peak_idx_d = w_idx;
                        end
                    end
                    if (data_in_endofpacket) begin
                        state_d = ST_EMIT;
                        word_d  = 3'd0;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_EMIT: begin
                if (!out_valid_q || data_out_ready) begin
                    if (out_valid_q && word_q == c_last_word) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        out_sop_d   = 1'b0;
                        out_eop_d   = 1'b0;
                        out_data_d  = 32'd0;
                    end else begin
                        word_d      = w_sel;
                        out_valid_d = 1'b1;
                        out_data_d  = w_word;
                        out_sop_d   = (w_sel == 3'd0);
                        out_eop_d   = (w_sel == c_last_word);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sum_q       <= '0;
            mom_q       <= '0;
            peak_q      <= 32'd0;
            peak_idx_q  <= 16'd0;
            chan_q      <= 16'd0;
            trunc_q     <= 1'b0;
            abort_q     <= 8'd0;
            word_q      <= 3'd0;
            out_data_q  <= 32'd0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            mom_q       <= mom_d;
            peak_q      <= peak_d;
            peak_idx_q  <= peak_idx_d;
            chan_q      <= chan_d;
            trunc_q     <= trunc_d;
            abort_q     <= abort_d;
            word_q      <= word_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
        end
    end

    assign data_out_data          = out_data_q;
    assign data_out_valid         = out_valid_q;
    assign data_out_startofpacket = out_sop_q;
    assign data_out_endofpacket   = out_eop_q;
    assign data_out_empty         = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_beam_profile_moments.sv
`default_nettype none
// ============================================================================
// Module   : tb_beam_profile_moments
// Brief    : Scoreboard bench; clamped and signed instances share one input stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_beam_profile_moments;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic        din_valid, din_sop, din_eop;
    logic        data_out_ready = 1'b1;

    logic        a_in_ready, a_valid, a_sop, a_eop;
    logic [31:0] a_data;
    logic [1:0]  a_empty;
    logic        b_in_ready, b_valid, b_sop, b_eop;
    logic [31:0] b_data;
    logic [1:0]  b_empty;

    int          n_cmp = 0;
    int          n_err = 0;
    int          ready_mode = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int          pos_a = 0, pos_b = 0;
    logic        stall_a = 1'b0, stall_b = 1'b0;
    logic [31:0] held_a, held_b;
    logic [2:0]  held_ctl_a, held_ctl_b;

    always #5 clk = ~clk;

    beam_profile_moments #(.MAX_CHANNELS(163), .CLAMP_NEG(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .data_in_data(din), .data_in_valid(din_valid), .data_in_ready(a_in_ready),
        .data_in_startofpacket(din_sop), .data_in_endofpacket(din_eop), .data_in_empty(2'b00),
        .data_out_data(a_data), .data_out_valid(a_valid), .data_out_ready(data_out_ready),
        .data_out_startofpacket(a_sop), .data_out_endofpacket(a_eop), .data_out_empty(a_empty)
    );

    beam_profile_moments #(.MAX_CHANNELS(163), .CLAMP_NEG(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .data_in_data(din), .data_in_valid(din_valid), .data_in_ready(b_in_ready),
        .data_in_startofpacket(din_sop), .data_in_endofpacket(din_eop), .data_in_empty(2'b00),
        .data_out_data(b_data), .data_out_valid(b_valid), .data_out_ready(data_out_ready),
        .data_out_startofpacket(b_sop), .data_out_endofpacket(b_eop), .data_out_empty(b_empty)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       data_out_ready = 1'b1;
            1:       data_out_ready = 1'($urandom_range(0, 1));
            default: data_out_ready = 1'b0;
        endcase
    end

    // Monitors: pop one expected word per accepted output beat
    always @(negedge clk) begin
        if (rst) begin
            pos_a   = 0;
            stall_a = 1'b0;
        end else begin
            if (stall_a) begin
                chk("hold_a_data", a_data, held_a);
                chk("hold_a_ctl", {29'd0, a_valid, a_sop, a_eop}, {29'd0, held_ctl_a});
            end
            if (a_valid && data_out_ready) begin
                if (qa.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_a: got %h expected no word", a_data);
                end else begin
                    chk($sformatf("a_word%0d", pos_a), a_data, qa.pop_front());
                    chk($sformatf("a_sop_eop%0d", pos_a), {30'd0, a_sop, a_eop},
                        {30'd0, pos_a == 0, pos_a == 4});
                end
                pos_a = (pos_a == 4) ? 0 : pos_a + 1;
            end
            stall_a    = a_valid && !data_out_ready;
            held_a     = a_data;
            held_ctl_a = {a_valid, a_sop, a_eop};
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pos_b   = 0;
            stall_b = 1'b0;
        end else begin
            if (stall_b) begin
                chk("hold_b_data", b_data, held_b);
                chk("hold_b_ctl", {29'd0, b_valid, b_sop, b_eop}, {29'd0, held_ctl_b});
            end
            if (b_valid && data_out_ready) begin
                if (qb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_b: got %h expected no word", b_data);
                end else begin
                    chk($sformatf("b_word%0d", pos_b), b_data, qb.pop_front());
                    chk($sformatf("b_sop_eop%0d", pos_b), {30'd0, b_sop, b_eop},
                        {30'd0, pos_b == 0, pos_b == 4});
                end
                pos_b = (pos_b == 4) ? 0 : pos_b + 1;
            end
            stall_b    = b_valid && !data_out_ready;
            held_b     = b_data;
            held_ctl_b = {b_valid, b_sop, b_eop};
        end
    end

    // which: bit0 -> clamped instance, bit1 -> signed instance
    task automatic push(input int which, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3, input logic [31:0] w4);
        if (which[0]) begin qa.push_back(w0); qa.push_back(w1); qa.push_back(w2); qa.push_back(w3); qa.push_back(w4); end
        if (which[1]) begin qb.push_back(w0); qb.push_back(w1); qb.push_back(w2); qb.push_back(w3); qb.push_back(w4); end
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic e);
        int g = 0;
        din = d; din_sop = s; din_eop = e; din_valid = 1'b1;
        while (!a_in_ready && g < 1000) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 1000) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: got ready=0 expected ready=1");
        end
        @(posedge clk); #1;
        din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    endtask

    task automatic frame_const(input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) send(v, i == 0, i == n - 1);
    endtask

    task automatic frame_spike();
        for (int i = 0; i < 163; i++) send((i == 50) ? 32'd1000 : 32'd0, i == 0, i == 162);
    endtask

    task automatic drain();
        int g = 0;
        while ((qa.size() != 0 || qb.size() != 0) && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 3000) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: got %0d words left expected 0", qa.size() + qb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        rst = 1'b1; din = 32'd0; din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_data", a_data, 32'd0);
        chk("rst_sop_eop", {30'd0, a_sop, a_eop}, 32'd0);
        chk("rst_empty", {30'd0, a_empty}, 32'd0);
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
        chk("rst_b_empty", {30'd0, b_empty}, 32'd0);

        // All ones, with latency check on the first result word
        push(3, 32'hC500_00A3, 32'h0, 32'd1, 32'd163, 32'd13203);
        frame_const(163, 32'd1);
        chk("lat_in_ready", {31'd0, a_in_ready}, 32'd0);
        chk("lat_valid_early", {31'd0, a_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_valid", {31'd0, a_valid}, 32'd1);
        chk("lat_sop", {31'd0, a_sop}, 32'd1);
        drain();

        push(3, 32'hC500_00A3, 32'd50, 32'd1000, 32'd1000, 32'd50000);
        frame_spike();
        drain();

        push(1, 32'hC500_00A3, 32'h0, 32'h0, 32'h0, 32'h0);
        push(2, 32'hC500_00A3, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FCD1, 32'hFFFE_FE21);
        frame_const(163, 32'hFFFF_FFFB);
        drain();

        push(3, 32'hC500_00A3, 32'h6000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        frame_const(163, 32'h7FFF_FFFF);
        drain();

        push(3, 32'hC500_00AA, 32'h8000_0000, 32'd1, 32'd163, 32'd13203);
        frame_const(170, 32'd1);
        drain();

        push(3, 32'hC500_0001, 32'h0, 32'd7, 32'd7, 32'h0);
        send(32'd7, 1'b1, 1'b1);
        drain();

        // Stray words outside a frame, then an aborted frame followed by a clean one
        send(32'd999, 1'b0, 1'b0);
        send(32'd999, 1'b0, 1'b1);
        send(32'd1, 1'b1, 1'b0);
        for (int i = 1; i < 100; i++) send(32'd1, 1'b0, 1'b0);
        push(3, 32'hC501_00A3, 32'h0, 32'd1, 32'd163, 32'd13203);
        frame_const(163, 32'd1);
        drain();

        // Random backpressure, reset while word 2 is presented
        ready_mode = 1;
        push(3, 32'hC501_00A3, 32'h0, 32'd1, 32'd163, 32'd13203);
        frame_const(163, 32'd1);
        g = 0;
        while (!(pos_a == 2 && a_valid) && g < 2000) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 2000) begin
            n_cmp++; n_err++;
            $display("FAIL word2_timeout: got pos %0d expected 2", pos_a);
        end
        ready_mode = 2;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        qa.delete();
        qb.delete();
        chk("midrst_valid", {31'd0, a_valid}, 32'd0);
        chk("midrst_data", a_data, 32'd0);
        chk("midrst_in_ready", {31'd0, a_in_ready}, 32'd1);
        chk("midrst_b_valid", {31'd0, b_valid}, 32'd0);
        ready_mode = 1;

        push(3, 32'hC500_00A3, 32'd50, 32'd1000, 32'd1000, 32'd50000);
        frame_spike();
        drain();
        ready_mode = 0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
